// File: rtl/scramble_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scramble_sequencer_pkg
// Description : Shared FSM state encoding, LFSR tap mask and small helper
//               functions for the scramble sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package scramble_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEL    = 3'd1,
        ST_FIRE   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Two-bit index to one-hot nibble
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] vec;
        case (idx)
            2'd0:    vec = 4'b0001;
            2'd1:    vec = 4'b0010;
            2'd2:    vec = 4'b0100;
            default: vec = 4'b1000;
        endcase
        return vec;
    endfunction

    // One shift of the LFSR: shift left, feedback enters at bit 0
    function automatic logic [15:0] lfsr_advance(input logic [15:0] value);
        return {value[14:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/scramble_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : scramble_sequencer_if
// Description : User-side inputs and cell-side outputs of the sequencer.
//               master = stimulus/user side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface scramble_sequencer_if;
    logic       scramble_go;
    logic       user_fire;
    logic       user_nRow;
    logic [3:0] user_sel;
    logic       user_error;
    logic       user_add_n;
    logic [3:0] row;
    logic [3:0] col;
    logic       fire_out;
    logic       add_n_out;
    logic       busy;
    logic       done;

    modport master (
        output scramble_go, user_fire, user_nRow, user_sel, user_error, user_add_n,
        input  row, col, fire_out, add_n_out, busy, done
    );

    modport slave (
        input  scramble_go, user_fire, user_nRow, user_sel, user_error, user_add_n,
        output row, col, fire_out, add_n_out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/scramble_sequencer_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Fibonacci LFSR that advances only when stepped.
//               A zero seed would lock the register, so it is forced to 1.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import scramble_sequencer_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        step,
    input  wire logic [15:0] seed,
    output logic      [15:0] value
);

    logic [15:0] seed_safe;

    assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

    // Load the seed on reset, otherwise shift once per step request
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= seed_safe;
        end else if (step) begin
            value <= lfsr_advance(value);
        end
    end

endmodule
`default_nettype wire

// File: rtl/scramble_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scramble_sequencer
// Description : Drives row/col enables, fire and add_n of the 4x4 cell grid.
//               Idle: registered passthrough of the user controls.
//               Scramble: NUM_MOVES pseudo-random add moves from an LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module scramble_sequencer
    import scramble_sequencer_pkg::*;
#(
    parameter int          NUM_MOVES  = 16,
    parameter int          GAP_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    scramble_sequencer_if.slave  bus
);

    localparam int             GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [7:0]     MOVES    = 8'(NUM_MOVES);

    state_t           state, next_state;
    logic [7:0]       move_cnt, move_cnt_next;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_next;
    logic [15:0]      lfsr_value, lfsr_stepped;
    logic             step;
    logic             end_of_move;
    logic [3:0]       move_vec;

    logic [3:0]       row_reg, col_reg, row_next, col_next;
    logic             fire_reg, add_n_reg, busy_reg, done_reg;
    logic             fire_next, add_n_next, busy_next, done_next;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .seed  (LFSR_SEED),
        .value (lfsr_value)
    );

    // The move is decoded from the value the LFSR takes on at this same edge
    assign lfsr_stepped = lfsr_advance(lfsr_value);
    assign move_vec     = onehot4(lfsr_stepped[1:0]);

    // State register and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            move_cnt <= 8'd0;
            gap_cnt  <= '0;
        end else begin
            state    <= next_state;
            move_cnt <= move_cnt_next;
            gap_cnt  <= gap_cnt_next;
        end
    end

    // Next state and next output values; outputs are registered so they
    // always describe the state being entered
    always_comb begin
        next_state    = state;
        move_cnt_next = move_cnt;
        gap_cnt_next  = gap_cnt;
        step          = 1'b0;
        end_of_move   = 1'b0;
        row_next      = row_reg;
        col_next      = col_reg;
        fire_next     = 1'b0;
        add_n_next    = 1'b0;
        busy_next     = 1'b1;
        done_next     = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (bus.scramble_go) begin
                    next_state    = ST_SEL;
                    move_cnt_next = 8'd0;
                    step          = 1'b1;
                    busy_next     = 1'b1;
                    row_next      = lfsr_stepped[2] ? 4'b0000 : move_vec;
                    col_next      = lfsr_stepped[2] ? move_vec : 4'b0000;
                end else begin
                    row_next   = (bus.user_error || bus.user_nRow)  ? 4'b0000 : bus.user_sel;
                    col_next   = (bus.user_error || !bus.user_nRow) ? 4'b0000 : bus.user_sel;
                    fire_next  = bus.user_fire & ~bus.user_error;
                    add_n_next = bus.user_add_n;
                end
            end
            ST_SEL: begin
                next_state    = ST_FIRE;
                fire_next     = 1'b1;
                move_cnt_next = move_cnt + 8'd1;
            end
            ST_FIRE: begin
                if (GAP_CYCLES == 0) begin
                    end_of_move = 1'b1;
                end else begin
                    next_state   = ST_GAP;
                    gap_cnt_next = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    end_of_move = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt + GAP_W'(1);
                end
            end
            ST_FINISH: begin
                next_state = ST_IDLE;
                busy_next  = 1'b0;
                row_next   = 4'b0000;
                col_next   = 4'b0000;
            end
            default: begin
                next_state = ST_IDLE;
                busy_next  = 1'b0;
                row_next   = 4'b0000;
                col_next   = 4'b0000;
            end
        endcase

        // Shared exit from FIRE (no gap) or the last gap cycle
        if (end_of_move) begin
            if (move_cnt < MOVES) begin
                next_state = ST_SEL;
                step       = 1'b1;
                row_next   = lfsr_stepped[2] ? 4'b0000 : move_vec;
                col_next   = lfsr_stepped[2] ? move_vec : 4'b0000;
            end else begin
                next_state = ST_FINISH;
                done_next  = 1'b1;
                row_next   = 4'b0000;
                col_next   = 4'b0000;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            row_reg   <= 4'b0000;
            col_reg   <= 4'b0000;
            fire_reg  <= 1'b0;
            add_n_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            row_reg   <= row_next;
            col_reg   <= col_next;
            fire_reg  <= fire_next;
            add_n_reg <= add_n_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bus.row       = row_reg;
    assign bus.col       = col_reg;
    assign bus.fire_out  = fire_reg;
    assign bus.add_n_out = add_n_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;

endmodule
`default_nettype wire

// File: tb/tb_scramble_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scramble_sequencer
// Description : Self-checking bench for scramble_sequencer. Three instances:
//               defaults, a one-move/no-gap corner and a zero-seed corner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scramble_sequencer;

    logic clk = 1'b0;
    logic reset;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] model_lfsr [3];

    scramble_sequencer_if bus0 ();
    scramble_sequencer_if bus1 ();
    scramble_sequencer_if bus2 ();

    scramble_sequencer dut0 (.clk(clk), .reset(reset), .bus(bus0));

    scramble_sequencer #(.NUM_MOVES(1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    scramble_sequencer #(.NUM_MOVES(5), .GAP_CYCLES(1), .LFSR_SEED(16'h0000)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11 feedback into the low end
    function automatic logic [15:0] ref_next(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    // Observed outputs packed as {row, col, fire, add_n, busy, done}
    function automatic logic [11:0] obs(input int w);
        case (w)
            0:       return {bus0.row, bus0.col, bus0.fire_out, bus0.add_n_out, bus0.busy, bus0.done};
            1:       return {bus1.row, bus1.col, bus1.fire_out, bus1.add_n_out, bus1.busy, bus1.done};
            default: return {bus2.row, bus2.col, bus2.fire_out, bus2.add_n_out, bus2.busy, bus2.done};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_user(input logic fire, input logic nrow, input logic [3:0] sel,
                            input logic err, input logic add);
        bus0.user_fire = fire; bus0.user_nRow = nrow; bus0.user_sel = sel;
        bus0.user_error = err; bus0.user_add_n = add;
        bus1.user_fire = fire; bus1.user_nRow = nrow; bus1.user_sel = sel;
        bus1.user_error = err; bus1.user_add_n = add;
        bus2.user_fire = fire; bus2.user_nRow = nrow; bus2.user_sel = sel;
        bus2.user_error = err; bus2.user_add_n = add;
    endtask

    task automatic set_go(input int w, input logic go);
        bus0.scramble_go = (w == 0) ? go : 1'b0;
        bus1.scramble_go = (w == 1) ? go : 1'b0;
        bus2.scramble_go = (w == 2) ? go : 1'b0;
    endtask

    function automatic logic [11:0] idle_expect(input logic fire, input logic nrow,
                                                input logic [3:0] sel, input logic err,
                                                input logic add);
        logic [3:0] r, c;
        r = (err || nrow)  ? 4'b0000 : sel;
        c = (err || !nrow) ? 4'b0000 : sel;
        return {r, c, fire & ~err, add, 1'b0, 1'b0};
    endfunction

    task automatic do_reset();
        set_go(0, 1'b0);
        set_user(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_lfsr[0] = 16'hACE1;
        model_lfsr[1] = 16'hACE1;
        model_lfsr[2] = 16'h0001;
    endtask

    // Start a scramble on instance w and check every cycle through the
    // first idle cycle afterwards; optional random user noise while busy
    task automatic run_scramble(input int w, input int n, input int g, input bit noise);
        int          period;
        int          total;
        int          fires;
        logic [15:0] v;
        logic [3:0]  er, ec;
        logic [11:0] exp, got;
        logic [31:0] rnd;
        period = 2 + g;
        total  = n * period;
        fires  = 0;
        v      = model_lfsr[w];
        er     = 4'b0000;
        ec     = 4'b0000;
        set_go(w, 1'b1);
        set_user(1'b1, 1'b0, 4'b0010, 1'b0, 1'b1);
        step();
        set_go(w, 1'b0);
        set_user(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int c = 0; c <= total + 1; c++) begin
            if (c < total) begin
                if (c % period == 0) begin
                    v  = ref_next(v);
                    er = v[2] ? 4'b0000 : (4'b0001 << v[1:0]);
                    ec = v[2] ? (4'b0001 << v[1:0]) : 4'b0000;
                end
                exp = {er, ec, (c % period == 1), 1'b0, 1'b1, 1'b0};
            end else if (c == total) begin
                exp = 12'b0000_0000_0011;
            end else begin
                exp = 12'b0;
            end
            got = obs(w);
            check($sformatf("scramble%0d_c%0d", w, c), 32'(got), 32'(exp));
            if (got[3]) fires++;
            if (noise && c <= total) begin
                rnd = $urandom;
                set_user(rnd[0], rnd[1], rnd[5:2], rnd[6], rnd[7]);
                set_go(w, rnd[8]);
            end else begin
                set_user(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
                set_go(w, 1'b0);
            end
            step();
        end
        check($sformatf("fire_count%0d", w), 32'(fires), 32'(n));
        model_lfsr[w] = v;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [11:0] exp0;
        int          fires;

        reset = 1'b1;
        set_go(0, 1'b0);
        set_user(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        step();
        for (int w = 0; w < 3; w++) check($sformatf("reset_state%0d", w), 32'(obs(w)), 32'd0);
        do_reset();

        // Directed idle passthrough
        set_user(1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
        step();
        set_user(1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
        check("idle_row_fire", 32'(obs(0)), 32'(12'b0100_0000_1000));
        step();
        check("idle_fire_one_cycle", 32'(obs(0)), 32'(12'b0100_0000_0000));
        set_user(1'b1, 1'b0, 4'b0100, 1'b1, 1'b0);
        step();
        check("idle_error", 32'(obs(0)), 32'd0);

        // Random idle passthrough on every instance
        for (int i = 0; i < 24; i++) begin
            rnd = $urandom;
            set_user(rnd[0], rnd[1], rnd[5:2], rnd[6], rnd[7]);
            exp0 = idle_expect(rnd[0], rnd[1], rnd[5:2], rnd[6], rnd[7]);
            step();
            for (int w = 0; w < 3; w++) check($sformatf("idle_rand%0d_%0d", w, i), 32'(obs(w)), 32'(exp0));
        end
        set_user(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        step();

        // Default scramble from reset, then a second scramble in a row
        run_scramble(0, 16, 4, 1'b0);
        run_scramble(0, 16, 4, 1'b1);

        // Determinism: reset restarts the same sequence
        do_reset();
        run_scramble(0, 16, 4, 1'b0);
        do_reset();
        run_scramble(0, 16, 4, 1'b1);

        // Reset after the fifth fire strobe
        do_reset();
        fires = 0;
        set_go(0, 1'b1);
        step();
        set_go(0, 1'b0);
        for (int c = 0; c < 200 && fires < 5; c++) begin
            if (obs(0) & 12'b0000_0000_1000) fires++;
            if (fires < 5) step();
        end
        check("mid_reach_5th_fire", 32'(fires), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_lfsr[0] = 16'hACE1;
        model_lfsr[1] = 16'hACE1;
        model_lfsr[2] = 16'h0001;
        check("mid_reset_outputs", 32'(obs(0)), 32'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("mid_quiet_%0d", c), 32'(obs(0)), 32'd0);
        end
        run_scramble(0, 16, 4, 1'b0);

        // Parameter corners
        run_scramble(1, 1, 0, 1'b0);
        run_scramble(1, 1, 0, 1'b1);
        run_scramble(2, 5, 1, 1'b1);
        run_scramble(2, 5, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
